// File: rtl/seven_seg_display_scheduler.sv
// Time-shares the 4-digit seven-segment display between NUM_SRC requesters.
// Round-robin with a fixed dwell per source; qualified urgent requests preempt.
// Optional: define SEVEN_SEG_SRC_INDICATOR_EN to show the source index (SHOW)
// or 4'hE (PREEMPT) in displayed_number[15:12].
module seven_seg_display_scheduler #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned DWELL_CYCLES = 100000000,
  parameter int unsigned CNT_W        = 27
) (
  input  logic                   clock_100Mhz,
  input  logic                   reset,
  input  logic [NUM_SRC-1:0]     src_req,
  input  logic [NUM_SRC-1:0]     src_urgent,
  input  logic [16*NUM_SRC-1:0]  src_value,
  output logic [NUM_SRC-1:0]     src_grant,
  output logic [15:0]            displayed_number,
  output logic                   display_valid,
  output logic                   slot_done
);

  localparam int unsigned       IDX_W    = $clog2(NUM_SRC);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, PREEMPT} state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   cur_idx, cur_idx_nx;
  logic [IDX_W-1:0]   rr_last, rr_last_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               slot_done_nx;
  logic [NUM_SRC-1:0] grant_nx;
  logic [15:0]        disp_nx;

  logic [NUM_SRC-1:0] urgent_q;
  logic               urg_found;
  logic [IDX_W-1:0]   urg_idx;
  logic               rr_found;
  logic [IDX_W-1:0]   rr_idx;
  logic [15:0]        cur_value;

  assign urgent_q = src_req & src_urgent;

  // Lowest-index qualified urgent request.
  always_comb begin
    urg_found = 1'b0;
    urg_idx   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!urg_found && urgent_q[k]) begin
        urg_found = 1'b1;
        urg_idx   = IDX_W'(k);
      end
    end
  end

  // Round-robin winner, searching from the slot after rr_last.
  always_comb begin
    logic [IDX_W-1:0] j;
    j        = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      j = IDX_W'((32'(rr_last) + 1 + k) % NUM_SRC);
      if (!rr_found && src_req[j]) begin
        rr_found = 1'b1;
        rr_idx   = j;
      end
    end
  end

  // Value of the currently granted source.
  always_comb begin
    cur_value = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (cur_idx == IDX_W'(k)) cur_value = src_value[16*k +: 16];
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      state            <= IDLE;
      cur_idx          <= '0;
      rr_last          <= IDX_W'(NUM_SRC - 1);
      cnt              <= '0;
      src_grant        <= '0;
      displayed_number <= '0;
      display_valid    <= 1'b0;
      slot_done        <= 1'b0;
    end else begin
      state            <= state_nx;
      cur_idx          <= cur_idx_nx;
      rr_last          <= rr_last_nx;
      cnt              <= cnt_nx;
      src_grant        <= grant_nx;
      displayed_number <= disp_nx;
      display_valid    <= (state_nx != IDLE);
      slot_done        <= slot_done_nx;
    end
  end

  // Next-state, grant index, dwell counter and round-robin pointer.
  always_comb begin
    state_nx     = state;
    cur_idx_nx   = cur_idx;
    rr_last_nx   = rr_last;
    cnt_nx       = cnt;
    slot_done_nx = 1'b0;
    if (urg_found) begin
      state_nx   = PREEMPT;
      cur_idx_nx = urg_idx;
      // Park the pointer just before the preempted source so it resumes first.
      if (state == SHOW)
        rr_last_nx = (cur_idx == '0) ? IDX_W'(NUM_SRC - 1) : cur_idx - 1'b1;
    end else if (state == SHOW && src_req[cur_idx] && cnt != CNT_LAST) begin
      cnt_nx = cnt + 1'b1;
    end else begin
      // IDLE arbitration, PREEMPT release, mid-slot drop or normal expiry.
      slot_done_nx = (state == SHOW) && src_req[cur_idx];
      cnt_nx       = '0;
      if (rr_found) begin
        state_nx   = SHOW;
        cur_idx_nx = rr_idx;
        rr_last_nx = rr_idx;
      end else begin
        state_nx   = IDLE;
      end
    end
  end

  // Next registered output values.
  always_comb begin
    grant_nx = '0;
    if (state_nx != IDLE) grant_nx[cur_idx_nx] = 1'b1;
    disp_nx = displayed_number;
    case (state)
`ifdef SEVEN_SEG_SRC_INDICATOR_EN
      SHOW:    disp_nx = {4'(cur_idx), cur_value[11:0]};
      PREEMPT: disp_nx = {4'hE, cur_value[11:0]};
`else
      SHOW:    disp_nx = cur_value;
      PREEMPT: disp_nx = cur_value;
`endif
      default: disp_nx = displayed_number;
    endcase
  end

endmodule

// File: doc/seven_seg_display_scheduler.md
Name: seven_seg_display_scheduler

Overview:
- Time-shares the 4-digit seven-segment display between up to NUM_SRC requesters.
- Requesters are counters, status words and debug values.
- Drives the 16-bit displayed_number input of the segment display controller.
- Normal sharing is round-robin with a fixed dwell time per source. An urgent request preempts it.

Parameters:
- NUM_SRC, 4, number of requesting sources (legal range 2..8).
- DWELL_CYCLES, 100000000, clock cycles each source stays on the display (1 s at 100 MHz).
- CNT_W, 27, dwell counter width; must satisfy 2^CNT_W >= DWELL_CYCLES.

Ports:
- clock_100Mhz  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- src_req  in  NUM_SRC  source i requests display time.
- src_urgent  in  NUM_SRC  preempt request; valid only while src_req[i] is also high.
- src_value  in  16*NUM_SRC  packed values; source i occupies [16i+15:16i].
- src_grant  out  NUM_SRC  one-hot (or zero) indication of the source currently shown.
- displayed_number  out  16  value sent to the segment controller.
- display_valid  out  1  high while any source is granted.
- slot_done  out  1  one-cycle pulse when a dwell slot expires normally.

Behaviour:
- Reset values:
  - src_grant=0, displayed_number=0, display_valid=0, slot_done=0.
  - Dwell counter=0, state=IDLE.
  - Round-robin pointer set so that source 0 wins first.
- States: IDLE, SHOW, PREEMPT. All outputs are registered.
- Round-robin selection:
  - Search starts at (last granted index + 1) mod NUM_SRC.
  - The first index with src_req high wins.
- Source qualification: requests use src_req & src_urgent for urgency. src_urgent without src_req is ignored.
- IDLE:
  - With no src_req bits set, all outputs hold reset values.
  - When any src_req is set, go to SHOW with the round-robin winner.
  - The grant is visible the cycle after the request is first seen. Latency is 1 cycle.
- SHOW:
  - Each cycle, displayed_number <= src_value of the granted source. The value is tracked live with 1-cycle latency.
  - The counter increments each cycle.
  - When the counter equals DWELL_CYCLES-1:
    - slot_done pulses for 1 cycle and the counter clears.
    - The next grant is the round-robin winner, excluding the current source if any other source requests.
    - If only the current source requests, it is re-granted and a new slot starts.
    - If no source requests, go to IDLE.
  - If the granted source drops src_req mid-slot:
    - Rearbitrate on the next cycle and clear the counter. No slot_done pulse.
    - If there are no requesters, go to IDLE: grant=0, valid=0, and displayed_number holds its last value.
- PREEMPT:
  - Entered from IDLE or SHOW when any qualified urgent request is present.
  - The lowest-index urgent source is granted on the next cycle.
  - The dwell counter is frozen; no dwell expiry applies.
  - If a lower-index urgent source arrives, it takes over on the next cycle.
  - When no qualified urgent request remains:
    - Return to SHOW, arbitrating round-robin from the saved pointer. This is the source preempted in SHOW, or the reset/IDLE pointer if entered from IDLE.
    - The preempted source resumes with a fresh dwell slot.
- Simultaneous events:
  - Urgent request and dwell expiry in the same cycle: urgent wins and slot_done is not pulsed.
  - Request drop and expiry in the same cycle: treated as a drop, so no slot_done pulse.
- src_grant is never multi-hot. display_valid == |src_grant at all times.
- Reset mid-slot or mid-preempt: all state returns to reset values on the next edge, regardless of inputs.

Optional Feature:
- Macro: SEVEN_SEG_SRC_INDICATOR_EN.
- Defined:
  - displayed_number[15:12] is replaced by the granted source index (zero-extended to 4 bits) in SHOW.
  - It is replaced by 4'hE in PREEMPT.
  - Bits [11:0] carry src_value[11:0] of the granted source.
- Undefined: all 16 bits come from src_value. No indicator logic is present.

Test Plan:
- Test parameters: NUM_SRC=4, DWELL_CYCLES=8.
- Scenario 1, reset and idle:
  - Stimulus: reset high 3 cycles, then src_req=0000 for 20 cycles.
  - Required: all outputs 0 throughout.
- Scenario 2, round-robin rotation:
  - Stimulus: src_req=1011, values 0x1111 / 0x2222 / 0x3333 / 0x4444 for sources 0..3.
  - Required: grant sequence 0001 -> 0010 -> 1000 -> 0001, each held 8 cycles.
  - Required: slot_done pulses at every change; displayed_number tracks the value one cycle after the grant.
- Scenario 3, mid-slot drop:
  - Stimulus: source 1 granted, src_req[1] deasserted at cycle 3 of its slot, src_req=0101.
  - Required: grant moves to 0100 on the next cycle; no slot_done; new slot lasts 8 cycles.
- Scenario 4, preemption:
  - Stimulus: source 0 shown at count 5; src_urgent[2]=src_req[2]=1 for 20 cycles.
  - Required: grant=0100 next cycle and held 20 cycles.
  - Required: after release, grant returns to round-robin from source 0 with a fresh 8-cycle slot; no slot_done at release.
- Scenario 5, collision:
  - Stimulus: urgent request asserted exactly at counter=7.
  - Required: no slot_done pulse; PREEMPT entered.
- Scenario 6, indicator option:
  - Stimulus: with SEVEN_SEG_SRC_INDICATOR_EN defined, source 3 value 0xABCD in SHOW; then the same source urgent.
  - Required: displayed_number=0x3BCD in SHOW, 0xEBCD in PREEMPT.
